mag_cmp_monitor: RTL

- Registered monitor directly downstream of the 4-bit magnitude comparator; consumes its EQ/GT/LT flags plus a sample strobe.
- Raises a debounced ALARM when A > B holds for SET_CNT consecutive samples; clears it after CLR_CNT consecutive non-GT samples.
- Keeps saturating per-result statistics and flags malformed (non-one-hot) comparator outputs.
- Feeds control/status logic that must not react to single-sample glitches.

---
 rtl/mag_cmp_pkg.sv | 24 ++
 rtl/mag_cmp_monitor_sat_counter.sv | 29 ++
 rtl/mag_cmp_monitor.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mag_cmp_pkg.sv
// Shared definitions for the comparator-output monitor: FSM encoding and
// the width helper for the debounce run counter.
package mag_cmp_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_PEND_SET = 2'd1;
    localparam logic [1:0] ST_ACTIVE   = 2'd2;
    localparam logic [1:0] ST_PEND_CLR = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = ST_IDLE,
        PEND_SET = ST_PEND_SET,
        ACTIVE   = ST_ACTIVE,
        PEND_CLR = ST_PEND_CLR
    } state_e;

    // Bits needed to hold 0..max(set_cnt, clr_cnt).
    function automatic int run_w(input int set_cnt, input int clr_cnt);
        int m;
        m = (set_cnt > clr_cnt) ? set_cnt : clr_cnt;
        return (m < 1) ? 1 : $clog2(m + 1);
    endfunction

endpackage

// File: rtl/mag_cmp_monitor_sat_counter.sv
// Saturating up-counter with synchronous reset and clear; clear beats increment.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] value
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (inc && (cnt_q != {CNT_W{1'b1}}))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign value = cnt_q;

endmodule

// File: rtl/mag_cmp_monitor.sv
// Debounced "A > B persistent" alarm on top of a 4-bit magnitude comparator's
// EQ/GT/LT flags, with saturating per-result statistics and a one-hot check.
module mag_cmp_monitor
    import mag_cmp_pkg::*;
#(
    parameter int SET_CNT = 3,
    parameter int CLR_CNT = 2,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             VALID,
    input  logic             EQ,
    input  logic             GT,
    input  logic             LT,
    input  logic             CLR_STATS,
    output logic             ALARM,
    output logic             RISE,
    output logic             FALL,
    output logic [1:0]       STATE,
    output logic [CNT_W-1:0] GT_CNT,
    output logic [CNT_W-1:0] EQ_CNT,
    output logic [CNT_W-1:0] LT_CNT,
    output logic             ERR
);

    localparam int RUN_W = run_w(SET_CNT, CLR_CNT);

    state_e           state_q, state_d;
    logic [RUN_W-1:0] run_q, run_d;
    logic             alarm_q, alarm_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic             err_q, err_d;
    logic             onehot, smp, bad;

    assign onehot = (EQ & ~GT & ~LT) | (~EQ & GT & ~LT) | (~EQ & ~GT & LT);
    assign smp    = VALID & onehot;
    assign bad    = VALID & ~onehot;

    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (smp) begin
            case (state_q)
                IDLE: begin
                    if (GT) begin
                        if (SET_CNT == 1) begin
                            state_d = ACTIVE;
                            rise_d  = 1'b1;
                        end else begin
                            state_d = PEND_SET;
                            run_d   = RUN_W'(1);
                        end
                    end
                end
                PEND_SET: begin
                    if (GT) begin
                        if (run_q + 1'b1 == RUN_W'(SET_CNT)) begin
                            state_d = ACTIVE;
                            rise_d  = 1'b1;
                            run_d   = '0;
                        end else begin
                            run_d = run_q + 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                        run_d   = '0;
                    end
                end
                ACTIVE: begin
                    if (!GT) begin
                        if (CLR_CNT == 1) begin
                            state_d = IDLE;
                            fall_d  = 1'b1;
                        end else begin
                            state_d = PEND_CLR;
                            run_d   = RUN_W'(1);
                        end
                    end
                end
                PEND_CLR: begin
                    if (!GT) begin
                        if (run_q + 1'b1 == RUN_W'(CLR_CNT)) begin
                            state_d = IDLE;
                            fall_d  = 1'b1;
                            run_d   = '0;
                        end else begin
                            run_d = run_q + 1'b1;
                        end
                    end else begin
                        state_d = ACTIVE;
                        run_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    run_d   = '0;
                end
            endcase
        end
        // ALARM is high exactly in the two states entered via a RISE.
        alarm_d = (state_d == ACTIVE) || (state_d == PEND_CLR);
    end

    always_comb begin
        err_d = err_q;
        if (CLR_STATS) err_d = 1'b0;
        else if (bad)  err_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            run_q   <= '0;
            alarm_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            run_q   <= run_d;
            alarm_q <= alarm_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            err_q   <= err_d;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_gt_cnt (
        .clk(clk), .rst(rst), .clr(CLR_STATS), .inc(smp & GT), .value(GT_CNT)
    );
    sat_counter #(.CNT_W(CNT_W)) u_eq_cnt (
        .clk(clk), .rst(rst), .clr(CLR_STATS), .inc(smp & EQ), .value(EQ_CNT)
    );
    sat_counter #(.CNT_W(CNT_W)) u_lt_cnt (
        .clk(clk), .rst(rst), .clr(CLR_STATS), .inc(smp & LT), .value(LT_CNT)
    );

    assign ALARM = alarm_q;
    assign RISE  = rise_q;
    assign FALL  = fall_q;
    assign STATE = state_q;
    assign ERR   = err_q;

endmodule
